// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, one-word-per-line instruction cache between datapath and memory control.
// Ports: CLK/nRST (async active-low reset); imemREN/imemaddr in, ihit/imemload out (datapath side);
//        flush in (invalidate all lines); iREN/iaddr out, iwait/iload in (memory controller side).
// Optional: define ICACHE_STATS_EN to add saturating 32-bit hit_count/miss_count outputs.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       state;
    logic [31:0]      miss_addr;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             miss_start;
    logic             fill;

    assign idx        = imemaddr[IDX_W+1:2];
    assign tag        = imemaddr[31:IDX_W+2];
    assign miss_idx   = miss_addr[IDX_W+1:2];
    assign hit        = (state == IDLE) && imemREN && valid[idx] && (tag_q[idx] == tag) && !flush;
    assign miss_start = (state == IDLE) && imemREN && !hit && !flush;
    // A flush arriving on the completing cycle wins, so the line is never written.
    assign fill       = (state == FETCH) && !iwait && !flush;
    assign ihit       = hit;
    assign imemload   = hit ? data_q[idx] : 32'h0;
    assign iREN       = (state == FETCH);
    assign iaddr      = iREN ? miss_addr : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= 32'h0;
        end else if (state == IDLE) begin
            if (flush) valid <= '0;
            if (miss_start) begin
                miss_addr <= imemaddr & ~32'h3;
                state     <= FETCH;
            end
        end else if (flush) begin
            valid <= '0;
            state <= IDLE;
        end else if (!iwait) begin
            valid[miss_idx] <= 1'b1;
            state           <= IDLE;
        end
    end

    // Tag/data storage is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_addr[31:IDX_W+2];
            data_q[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (hit && hit_count != 32'hFFFFFFFF) hit_count <= hit_count + 32'd1;
            if (miss_start && miss_count != 32'hFFFFFFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
